health_ctrl: RTL and testbench

//  Per-fighter health sequencer. Holds the fighter's current health points and applies damage and heal

---
 rtl/health_ctrl_if.sv | 24 ++
 rtl/health_ctrl.sv | 110 +++++++++++
 tb/tb_health_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/health_ctrl_if.sv
// Request/status bundle between the combat logic and one fighter's health sequencer.
// The combat logic is the master; health_ctrl is the slave.
interface health_ctrl_if;
    logic       Frame_Tick;
    logic       New_Round;
    logic       Hit;
    logic [2:0] Dmg;
    logic       Heal;
    logic [2:0] Health_Count;
    logic [4:0] Health_Mask;
    logic       Invuln;
    logic       Is_Dead;
    logic       Hit_Ack;

    modport master (
        output Frame_Tick, New_Round, Hit, Dmg, Heal,
        input  Health_Count, Health_Mask, Invuln, Is_Dead, Hit_Ack
    );

    modport slave (
        input  Frame_Tick, New_Round, Hit, Dmg, Heal,
        output Health_Count, Health_Mask, Invuln, Is_Dead, Hit_Ack
    );
endinterface

// File: rtl/health_ctrl.sv
// Per-fighter health sequencer: damage/heal arbitration, post-hit invulnerability
// window counted in frames, and the blinking box mask for the health display.
module health_ctrl #(
    parameter logic [2:0] MAX_HEALTH    = 3'd5,
    parameter logic [7:0] INVULN_FRAMES = 8'd60,
    parameter logic [3:0] BLINK_FRAMES  = 4'd8
) (
    input logic          Clk,
    input logic          Reset_n,
    health_ctrl_if.slave bus
);
    typedef enum logic [1:0] {ALIVE, INVULN, DEAD} state_t;

    state_t     state, state_nxt;
    logic [2:0] count, count_nxt;
    logic [7:0] frame_cnt, frame_nxt;
    logic [3:0] blink_cnt, blink_cnt_nxt;
    logic       blink, blink_nxt;
    logic       ack_nxt;
    logic       hit_ok;

    function automatic logic [4:0] therm(input logic [2:0] n);
        logic [4:0] m;
        m = '0;
        for (int unsigned i = 0; i < 5; i++) begin
            if (i < 32'(n)) m[i] = 1'b1;
        end
        return m;
    endfunction

    assign hit_ok = (state == ALIVE) && bus.Hit && (bus.Dmg != 3'd0);

    always_comb begin
        state_nxt     = state;
        count_nxt     = count;
        frame_nxt     = frame_cnt;
        blink_cnt_nxt = blink_cnt;
        blink_nxt     = blink;
        ack_nxt       = 1'b0;
        if (bus.New_Round) begin
            state_nxt     = ALIVE;
            count_nxt     = MAX_HEALTH;
            frame_nxt     = '0;
            blink_cnt_nxt = '0;
            blink_nxt     = 1'b0;
        end else if (hit_ok) begin
            // An accepted hit swallows any heal or frame tick in the same cycle
            ack_nxt = 1'b1;
            if (bus.Dmg >= count) begin
                count_nxt = '0;
                state_nxt = DEAD;
            end else begin
                count_nxt = count - bus.Dmg;
                if (INVULN_FRAMES != 8'd0) begin
                    state_nxt     = INVULN;
                    frame_nxt     = INVULN_FRAMES;
                    blink_cnt_nxt = '0;
                    blink_nxt     = 1'b0;
                end
            end
        end else begin
            if (bus.Heal && (state != DEAD) && (count < MAX_HEALTH)) begin
                count_nxt = count + 3'd1;
            end
            if ((state == INVULN) && bus.Frame_Tick) begin
                if (frame_cnt <= 8'd1) begin
                    state_nxt     = ALIVE;
                    frame_nxt     = '0;
                    blink_cnt_nxt = '0;
                    blink_nxt     = 1'b0;
                end else begin
                    frame_nxt = frame_cnt - 8'd1;
                    if (blink_cnt >= BLINK_FRAMES - 4'd1) begin
                        blink_cnt_nxt = '0;
                        blink_nxt     = ~blink;
                    end else begin
                        blink_cnt_nxt = blink_cnt + 4'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state           <= ALIVE;
            count           <= MAX_HEALTH;
            frame_cnt       <= '0;
            blink_cnt       <= '0;
            blink           <= 1'b0;
            bus.Hit_Ack     <= 1'b0;
            bus.Health_Mask <= therm(MAX_HEALTH);
            bus.Invuln      <= 1'b0;
            bus.Is_Dead     <= 1'b0;
        end else begin
            state           <= state_nxt;
            count           <= count_nxt;
            frame_cnt       <= frame_nxt;
            blink_cnt       <= blink_cnt_nxt;
            blink           <= blink_nxt;
            bus.Hit_Ack     <= ack_nxt;
            // Mask is decoded from next-state values so it lands with the count
            bus.Health_Mask <= ((state_nxt == DEAD) || blink_nxt) ? '0 : therm(count_nxt);
            bus.Invuln      <= (state_nxt == INVULN);
            bus.Is_Dead     <= (state_nxt == DEAD);
        end
    end

    assign bus.Health_Count = count;
endmodule

// File: tb/tb_health_ctrl.sv
// Self-checking bench for health_ctrl: directed game scenarios followed by random
// traffic, all compared against a behavioural health/invulnerability model.
module tb_health_ctrl;
    localparam int MAXH = 5;
    localparam int INV  = 60;
    localparam int BLK  = 8;

    logic Clk;
    logic Reset_n;
    health_ctrl_if bus();

    health_ctrl #(
        .MAX_HEALTH   (3'(MAXH)),
        .INVULN_FRAMES(8'(INV)),
        .BLINK_FRAMES (4'(BLK))
    ) dut (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .bus    (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int tests  = 0;
    int failed = 0;

    // Model: health points, dead flag, frames of protection left, ticks since the hit
    int m_hp;
    bit m_dead;
    int m_left;
    int m_ticks;
    bit m_ack;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hp = MAXH; m_dead = 0; m_left = 0; m_ticks = 0; m_ack = 0;
    endtask

    function automatic int exp_mask();
        bit blink_on;
        blink_on = (m_left > 0) && (((m_ticks / BLK) % 2) == 1);
        return (m_dead || blink_on) ? 0 : ((1 << m_hp) - 1);
    endfunction

    task automatic check_model(input string tag);
        check_eq({tag, ".count"}, 32'(bus.Health_Count), 32'(m_hp));
        check_eq({tag, ".mask"},  32'(bus.Health_Mask),  32'(exp_mask()));
        check_eq({tag, ".invuln"}, 32'(bus.Invuln),      32'(m_left > 0));
        check_eq({tag, ".dead"},  32'(bus.Is_Dead),      32'(m_dead));
        check_eq({tag, ".ack"},   32'(bus.Hit_Ack),      32'(m_ack));
    endtask

    task automatic step(input bit nr, input bit hit, input logic [2:0] dmg,
                        input bit heal, input bit tick, input string tag);
        @(negedge Clk);
        bus.New_Round  = nr;
        bus.Hit        = hit;
        bus.Dmg        = dmg;
        bus.Heal       = heal;
        bus.Frame_Tick = tick;
        @(posedge Clk);
        #1;
        m_ack = 0;
        if (nr) begin
            model_reset();
        end else if (hit && !m_dead && m_left == 0 && dmg != 0) begin
            m_ack = 1;
            m_hp  = (int'(dmg) >= m_hp) ? 0 : m_hp - int'(dmg);
            if (m_hp == 0) m_dead = 1;
            else if (INV > 0) begin
                m_left = INV; m_ticks = 0;
            end
        end else begin
            if (heal && !m_dead && m_hp < MAXH) m_hp++;
            if (tick && m_left > 0) begin
                m_left--; m_ticks++;
            end
        end
        check_model(tag);
    endtask

    task automatic ticks(input int n, input string tag);
        for (int i = 0; i < n; i++) step(0, 0, 3'd0, 0, 1, tag);
    endtask

    initial begin
        bus.New_Round = 0; bus.Hit = 0; bus.Dmg = '0; bus.Heal = 0; bus.Frame_Tick = 0;
        Reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        check_eq("rst.count", 32'(bus.Health_Count), 32'd5);
        check_eq("rst.mask",  32'(bus.Health_Mask),  32'h1f);
        check_eq("rst.invuln", 32'(bus.Invuln), 32'd0);
        check_eq("rst.ack",   32'(bus.Hit_Ack), 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;

        step(0, 1, 3'd2, 0, 0, "hit2");
        check_eq("hit2.count", 32'(bus.Health_Count), 32'd3);
        check_eq("hit2.mask",  32'(bus.Health_Mask),  32'h07);
        check_eq("hit2.ack",   32'(bus.Hit_Ack), 32'd1);
        step(0, 0, 3'd0, 0, 0, "ack_once");
        check_eq("ack_once", 32'(bus.Hit_Ack), 32'd0);
        ticks(8, "blink_a");
        check_eq("blink8.mask", 32'(bus.Health_Mask), 32'd0);
        ticks(8, "blink_b");
        check_eq("blink16.mask", 32'(bus.Health_Mask), 32'h07);
        ticks(14, "inv30");
        step(0, 1, 3'd1, 0, 0, "hit_ignored");
        check_eq("ignored.count", 32'(bus.Health_Count), 32'd3);
        check_eq("ignored.ack",   32'(bus.Hit_Ack), 32'd0);
        ticks(29, "inv59");
        check_eq("tick59.invuln", 32'(bus.Invuln), 32'd1);
        ticks(1, "inv60");
        check_eq("tick60.invuln", 32'(bus.Invuln), 32'd0);
        check_eq("exit.mask", 32'(bus.Health_Mask), 32'h07);

        step(0, 0, 3'd0, 1, 0, "heal4");
        step(0, 1, 3'd1, 1, 0, "hit_heal");
        check_eq("hit_heal.count", 32'(bus.Health_Count), 32'd3);
        ticks(INV, "wait_a");
        step(0, 1, 3'd1, 0, 0, "hit_to2");
        ticks(INV, "wait_b");
        step(0, 1, 3'd7, 0, 0, "overkill");
        check_eq("overkill.count", 32'(bus.Health_Count), 32'd0);
        check_eq("overkill.dead",  32'(bus.Is_Dead), 32'd1);
        check_eq("overkill.mask",  32'(bus.Health_Mask), 32'd0);
        step(0, 0, 3'd0, 1, 0, "dead_heal");
        check_eq("dead_heal.count", 32'(bus.Health_Count), 32'd0);
        step(1, 1, 3'd3, 0, 0, "round_hit");
        check_eq("round.count", 32'(bus.Health_Count), 32'd5);
        check_eq("round.dead",  32'(bus.Is_Dead), 32'd0);
        check_eq("round.ack",   32'(bus.Hit_Ack), 32'd0);
        step(0, 0, 3'd0, 1, 0, "heal_sat");
        check_eq("heal_sat.count", 32'(bus.Health_Count), 32'd5);

        step(0, 1, 3'd2, 0, 0, "pre_rst");
        ticks(10, "pre_rst_t");
        #2 Reset_n = 1'b0;
        #1;
        check_eq("arst.count",  32'(bus.Health_Count), 32'd5);
        check_eq("arst.mask",   32'(bus.Health_Mask),  32'h1f);
        check_eq("arst.invuln", 32'(bus.Invuln), 32'd0);
        check_eq("arst.dead",   32'(bus.Is_Dead), 32'd0);
        model_reset();
        @(negedge Clk);
        Reset_n = 1'b1;

        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(63) == 0, $urandom_range(7) == 0, 3'($urandom_range(7)),
                 $urandom_range(5) == 0, $urandom_range(1) == 1, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
